rom_fetch_engine: RTL



---
 rtl/rom_fetch_pkg.sv | 19 +
 rtl/rom_fetch_fifo.sv | 50 +++++
 rtl/rom_fetch_engine.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the ROM burst fetch engine and its response buffer.
package rom_fetch_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_FETCH
    } state_e;

    // Sideband carried alongside each buffered read word.
    typedef struct packed {
        logic last;
        logic err;
    } rsp_tag_t;

endpackage

// File: rtl/rom_fetch_fifo.sv
// Two-entry synchronous FIFO holding captured ROM beats; push and pop may coincide.
module rom_fetch_fifo
    import rom_fetch_pkg::*;
#(
    parameter type entry_t = logic
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  entry_t           i_push_data,
    input  logic             i_pop,
    output entry_t           o_pop_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    entry_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok, pop_ok;

    assign o_full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign o_empty    = (count_q == '0);
    assign o_count    = count_q;
    assign o_pop_data = mem_q[rd_ptr_q];
    assign push_ok    = i_push && !o_full;
    assign pop_ok     = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
    end

endmodule

// File: rtl/rom_fetch_engine.sv
// Burst read front-end for a one-cycle-latency synchronous ROM with a 2-beat response buffer.
// Define ROM_FETCH_BOUNDS_EN to flag beats at or beyond ROM_DEPTH as errors instead of reading them.
module rom_fetch_engine
    import rom_fetch_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int LEN_WIDTH     = 8,
    parameter int ROM_DEPTH     = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
    input  logic [LEN_WIDTH-1:0]     i_req_len,
    output logic [ADDRESS_WIDTH-1:0] o_rom_address,
    input  logic [DATA_WIDTH-1:0]    i_rom_read_data,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [DATA_WIDTH-1:0]    o_rsp_data,
    output logic                     o_rsp_last,
    output logic                     o_rsp_err,
    output logic                     o_busy
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        rsp_tag_t              tag;
    } entry_t;

`ifdef ROM_FETCH_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    localparam int CW1 = CNT_W + 1;

    state_e                   state_q;
    logic                     req_ready_q;
    logic [ADDRESS_WIDTH-1:0] cur_addr_q, rom_addr_q;
    logic [LEN_WIDTH-1:0]     remaining_q;
    logic                     inflight_q;
    rsp_tag_t                 tag_q;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    entry_t           cap, head, src;
    logic             accept, issue, oob, push, pop, rsp_valid;

    assign o_req_ready = req_ready_q && !i_rst;
    assign accept      = i_req_valid && o_req_ready;

    // Credit counts the beat whose ROM data is still one cycle away.
    assign issue = (state_q == ST_FETCH) && !fifo_full &&
                   ((CW1'(fifo_count) + CW1'(inflight_q)) < CW1'(FIFO_DEPTH));
    assign oob   = BOUNDS_EN && (64'(cur_addr_q) >= 64'(ROM_DEPTH));

    assign o_rom_address = (issue && !oob) ? cur_addr_q : rom_addr_q;

    assign cap.data = tag_q.err ? '0 : i_rom_read_data;
    assign cap.tag  = tag_q;

    // An empty buffer lets the freshly captured beat go straight out; it is
    // only written into the buffer if the consumer does not take it.
    assign src       = fifo_empty ? cap : head;
    assign rsp_valid = !fifo_empty || inflight_q;
    assign push      = inflight_q && !(fifo_empty && i_rsp_ready);
    assign pop       = !fifo_empty && i_rsp_ready;

    assign o_rsp_valid = rsp_valid;
    assign o_rsp_data  = rsp_valid ? src.data : '0;
    assign o_rsp_last  = rsp_valid && src.tag.last;
    assign o_rsp_err   = rsp_valid && src.tag.err;
    assign o_busy      = (state_q != ST_IDLE) || inflight_q || !fifo_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rom_addr_q  <= '0;
            inflight_q  <= 1'b0;
            tag_q       <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                tag_q       <= '{last: (remaining_q == '0), err: oob};
                cur_addr_q  <= cur_addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
                if (!oob) rom_addr_q <= cur_addr_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_FETCH;
                        req_ready_q <= 1'b0;
                        cur_addr_q  <= i_req_addr;
                        remaining_q <= i_req_len;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (issue && remaining_q == '0) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    rom_fetch_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data (cap),
        .i_pop       (pop),
        .o_pop_data  (head),
        .o_count     (fifo_count),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

endmodule
